// File: rtl/floo_wh_out_arbiter.sv
// floo_wh_out_arbiter: wormhole output-port arbiter with round-robin packet selection
//
// Picks one of NumInp flit streams with round-robin priority. Once the first
// flit of a multi-flit packet is accepted, the chosen input is held until its
// last flit is accepted. Accepted flits land in a one-entry output register.
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   rst_i        asynchronous active-high reset
//   valid_i      per-input flit valid
//   ready_o      per-input flit accept (only the granted input can be high)
//   data_i       per-input flit payload
//   last_i       per-input last-flit-of-packet flag
//   valid_o      output register holds a flit
//   ready_i      downstream accept
//   data_o       registered payload
//   last_o       registered last flag
//   idx_o        source input of the flit in data_o
//   locked_o     high while a packet holds the output
//   stall_cnt_o  saturating count of cycles with valid_o && !ready_i
//
// Build option: define FLOO_WH_ARB_STALL_CNT_EN to include the stall counter;
// without it stall_cnt_o is tied to zero.
module floo_wh_out_arbiter #(
    parameter  int unsigned NumInp    = 4,
    parameter  int unsigned DataWidth = 64,
    localparam int unsigned IdxW      = $clog2(NumInp)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumInp-1:0]                  valid_i,
    output logic [NumInp-1:0]                  ready_o,
    input  logic [NumInp-1:0][DataWidth-1:0]   data_i,
    input  logic [NumInp-1:0]                  last_i,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [DataWidth-1:0]               data_o,
    output logic                               last_o,
    output logic [IdxW-1:0]                    idx_o,
    output logic                               locked_o,
    output logic [15:0]                        stall_cnt_o
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [IdxW-1:0]      lock_idx_q, lock_idx_d;
    logic                 valid_q, valid_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 last_q, last_d;
    logic [IdxW-1:0]      idx_q, idx_d;

    logic [IdxW-1:0]      idle_gnt, gnt;
    logic                 any_valid, gnt_vld, slot_free, hs;

    // (base + off) mod NumInp for off < NumInp
    function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NumInp) s = s - NumInp;
        return s[IdxW-1:0];
    endfunction

    // Round-robin search starting at ptr; scanning downward lets the
    // closest-to-ptr valid input win.
    always_comb begin
        idle_gnt  = ptr_q;
        any_valid = 1'b0;
        for (int k = int'(NumInp) - 1; k >= 0; k--) begin
            if (valid_i[wrap_inc(ptr_q, 32'(k))]) begin
                idle_gnt  = wrap_inc(ptr_q, 32'(k));
                any_valid = 1'b1;
            end
        end
    end

    // A locked packet keeps the grant even while its source has no valid flit.
    assign gnt       = (state_q == LOCKED) ? lock_idx_q : idle_gnt;
    assign gnt_vld   = (state_q == LOCKED) ? valid_i[lock_idx_q] : any_valid;
    assign slot_free = !valid_q || ready_i;
    assign hs        = gnt_vld && slot_free;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        if (hs) begin
            if (last_i[gnt]) begin
                state_d = IDLE;
                ptr_d   = wrap_inc(gnt, 32'd1);
            end else if (state_q == IDLE) begin
                state_d    = LOCKED;
                lock_idx_d = gnt;
            end
        end
    end

    // Output logic
    always_comb begin
        ready_o      = '0;
        ready_o[gnt] = hs;
        locked_o     = (state_q == LOCKED);
    end

    // Output register: a new flit replaces the drained one in the same cycle.
    always_comb begin
        valid_d = hs ? 1'b1 : (ready_i ? 1'b0 : valid_q);
        data_d  = hs ? data_i[gnt] : data_q;
        last_d  = hs ? last_i[gnt] : last_q;
        idx_d   = hs ? gnt : idx_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign idx_o   = idx_q;

`ifdef FLOO_WH_ARB_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb stall_d = (valid_q && !ready_i && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
